// File: rtl/sys_pll_reset_sequencer_if.sv
// Bundle of the PLL-lock inputs and the reset/status outputs of the reset sequencer.
// The master drives lock and requests; the slave is the sequencer itself.
interface sys_pll_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             soft_rst_req;
    logic             lol_clear;
    logic             sdram_rst;
    logic             sys_rst;
    logic             ready;
    logic             lol_sticky;
    logic [CNT_W-1:0] lol_count;

    modport master (
        output pll_locked, soft_rst_req, lol_clear,
        input  sdram_rst, sys_rst, ready, lol_sticky, lol_count
    );

    modport slave (
        input  pll_locked, soft_rst_req, lol_clear,
        output sdram_rst, sys_rst, ready, lol_sticky, lol_count
    );
endinterface

// File: rtl/sys_pll_reset_sequencer.sv
// Qualifies the asynchronous PLL lock, then releases the SDRAM reset and later the
// system reset; counts loss-of-lock events once release has begun.
module sys_pll_reset_sequencer #(
    parameter int SYNC_STAGES          = 2,
    parameter int LOCK_STABLE_CYCLES   = 256,
    parameter int RESET_STAGGER_CYCLES = 16,
    parameter int CNT_W                = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    sys_pll_reset_sequencer_if.slave  bus
);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int STG_W = $clog2(RESET_STAGGER_CYCLES) + 1;
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [STG_W-1:0] STG_MAX = STG_W'(RESET_STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        STABLE    = 2'd1,
        REL_SDRAM = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lk_s;
    state_t                 state_r, state_s;
    logic [STB_W-1:0]       stb_cnt_r, stb_cnt_s;
    logic [STG_W-1:0]       stg_cnt_r, stg_cnt_s;
    logic                   loss_s;
    logic                   sdram_rst_r, sdram_rst_s;
    logic                   sys_rst_r, sys_rst_s;
    logic                   ready_r, ready_s;
    logic                   lol_sticky_r, lol_sticky_s;
    logic [CNT_W-1:0]       lol_count_r, lol_count_s;

    assign lk_s = sync_r[SYNC_STAGES-1];

    // Lock synchroniser: the only reader of pll_locked
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    // Next-state, counters, loss detection and next output values
    always_comb begin
        state_s   = state_r;
        stb_cnt_s = stb_cnt_r;
        stg_cnt_s = stg_cnt_r;
        loss_s    = 1'b0;
        case (state_r)
            HOLD: begin
                if (lk_s && !bus.soft_rst_req) begin
                    state_s   = STABLE;
                    stb_cnt_s = STB_W'(1);
                end else begin
                    stb_cnt_s = '0;
                end
            end
            STABLE: begin
                // A lock drop here is still qualification, never a loss event
                if (!lk_s || bus.soft_rst_req) begin
                    state_s   = HOLD;
                    stb_cnt_s = '0;
                end else if (stb_cnt_r == STB_MAX) begin
                    state_s   = REL_SDRAM;
                    stb_cnt_s = '0;
                    stg_cnt_s = STG_W'(1);
                end else begin
                    stb_cnt_s = stb_cnt_r + STB_W'(1);
                end
            end
            REL_SDRAM: begin
                if (!lk_s) begin
                    loss_s    = 1'b1;
                    state_s   = HOLD;
                    stg_cnt_s = '0;
                end else if (bus.soft_rst_req) begin
                    state_s   = HOLD;
                    stg_cnt_s = '0;
                end else if (stg_cnt_r == STG_MAX) begin
                    state_s   = RUN;
                    stg_cnt_s = '0;
                end else begin
                    stg_cnt_s = stg_cnt_r + STG_W'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    loss_s  = 1'b1;
                    state_s = HOLD;
                end else if (bus.soft_rst_req) begin
                    state_s = HOLD;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s   = HOLD;
                stb_cnt_s = '0;
                stg_cnt_s = '0;
            end
        endcase

        sdram_rst_s = !((state_s == REL_SDRAM) || (state_s == RUN));
        sys_rst_s   = (state_s != RUN);
        ready_s     = (state_s == RUN);

        // A loss coinciding with a clear leaves exactly this one event recorded
        if (loss_s) begin
            lol_sticky_s = 1'b1;
            if (bus.lol_clear) begin
                lol_count_s = CNT_W'(1);
            end else if (lol_count_r == CNT_MAX) begin
                lol_count_s = lol_count_r;
            end else begin
                lol_count_s = lol_count_r + CNT_W'(1);
            end
        end else if (bus.lol_clear) begin
            lol_sticky_s = 1'b0;
            lol_count_s  = '0;
        end else begin
            lol_sticky_s = lol_sticky_r;
            lol_count_s  = lol_count_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= HOLD;
            stb_cnt_r    <= '0;
            stg_cnt_r    <= '0;
            sdram_rst_r  <= 1'b1;
            sys_rst_r    <= 1'b1;
            ready_r      <= 1'b0;
            lol_sticky_r <= 1'b0;
            lol_count_r  <= '0;
        end else begin
            state_r      <= state_s;
            stb_cnt_r    <= stb_cnt_s;
            stg_cnt_r    <= stg_cnt_s;
            sdram_rst_r  <= sdram_rst_s;
            sys_rst_r    <= sys_rst_s;
            ready_r      <= ready_s;
            lol_sticky_r <= lol_sticky_s;
            lol_count_r  <= lol_count_s;
        end
    end

    assign bus.sdram_rst  = sdram_rst_r;
    assign bus.sys_rst    = sys_rst_r;
    assign bus.ready      = ready_r;
    assign bus.lol_sticky = lol_sticky_r;
    assign bus.lol_count  = lol_count_r;
endmodule

// File: tb/tb_sys_pll_reset_sequencer.sv
// Directed bench: default-parameter instance for release timing, a short-parameter
// instance (LOCK_STABLE_CYCLES=4, RESET_STAGGER_CYCLES=2) for counter saturation.
module tb_sys_pll_reset_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sys_pll_reset_sequencer_if #(.CNT_W(8)) bus1 ();
    sys_pll_reset_sequencer_if #(.CNT_W(8)) bus2 ();

    sys_pll_reset_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    sys_pll_reset_sequencer #(
        .SYNC_STAGES          (2),
        .LOCK_STABLE_CYCLES   (4),
        .RESET_STAGGER_CYCLES (2),
        .CNT_W                (8)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {sdram_rst, sys_rst, ready}
    function automatic logic [2:0] rst1();
        return {bus1.sdram_rst, bus1.sys_rst, bus1.ready};
    endfunction

    function automatic logic [2:0] rst2();
        return {bus2.sdram_rst, bus2.sys_rst, bus2.ready};
    endfunction

    // Lock already rising/primed; expect sdram release on tick n_sdram and RUN 16 later
    task automatic expect_release(input string name, input int n_sdram);
        tick(n_sdram - 1);
        n_cmp++;
        if (rst1() !== 3'b110) begin
            $display("FAIL %s_early: got %b want 110", name, rst1()); n_err++;
        end
        tick(1);
        n_cmp++;
        if (rst1() !== 3'b010) begin
            $display("FAIL %s_sdram: got %b want 010", name, rst1()); n_err++;
        end
        tick(15);
        n_cmp++;
        if (rst1() !== 3'b010) begin
            $display("FAIL %s_stagger: got %b want 010", name, rst1()); n_err++;
        end
        tick(1);
        n_cmp++;
        if (rst1() !== 3'b001) begin
            $display("FAIL %s_run: got %b want 001", name, rst1()); n_err++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.pll_locked = 1'b1; bus1.soft_rst_req = 1'b0; bus1.lol_clear = 1'b0;
        bus2.pll_locked = 1'b0; bus2.soft_rst_req = 1'b0; bus2.lol_clear = 1'b0;
        tick(4);
        n_cmp++;
        if ({rst1(), bus1.lol_sticky, bus1.lol_count} !== {3'b110, 1'b0, 8'd0}) begin
            $display("FAIL reset_state: got %b/%b/%0d want 110/0/0", rst1(), bus1.lol_sticky, bus1.lol_count);
            n_err++;
        end
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        // Edge 0 is the first edge after rst drops: sdram at 258, run at 274
        expect_release("powerup", 259);
        n_cmp++;
        if (bus1.lol_count !== 8'd0) begin
            $display("FAIL powerup_count: got %0d want 0", bus1.lol_count); n_err++;
        end
    endtask

    task automatic test_loss_in_run();
        bus1.pll_locked = 1'b0;
        tick(2);
        n_cmp++;
        if (rst1() !== 3'b001) begin
            $display("FAIL loss_before: got %b want 001", rst1()); n_err++;
        end
        tick(1);
        n_cmp++;
        if ({rst1(), bus1.lol_sticky, bus1.lol_count} !== {3'b110, 1'b1, 8'd1}) begin
            $display("FAIL loss_assert: got %b/%b/%0d want 110/1/1", rst1(), bus1.lol_sticky, bus1.lol_count);
            n_err++;
        end
        bus1.pll_locked = 1'b1;
        expect_release("relock", 259);
    endtask

    task automatic test_soft_reset();
        bus1.soft_rst_req = 1'b1;
        tick(1);
        n_cmp++;
        if ({rst1(), bus1.lol_sticky, bus1.lol_count} !== {3'b110, 1'b1, 8'd1}) begin
            $display("FAIL soft_assert: got %b/%b/%0d want 110/1/1", rst1(), bus1.lol_sticky, bus1.lol_count);
            n_err++;
        end
        tick(4);
        n_cmp++;
        if (rst1() !== 3'b110) begin
            $display("FAIL soft_hold: got %b want 110", rst1()); n_err++;
        end
        bus1.soft_rst_req = 1'b0;
        // Synchroniser already primed: qualification starts on the first edge
        expect_release("soft_rerelease", 257);
        n_cmp++;
        if (bus1.lol_count !== 8'd1) begin
            $display("FAIL soft_count: got %0d want 1", bus1.lol_count); n_err++;
        end
    endtask

    task automatic test_rst_in_rel();
        bus1.pll_locked = 1'b0;
        tick(3);
        n_cmp++;
        if (bus1.lol_count !== 8'd2) begin
            $display("FAIL rel_pre_count: got %0d want 2", bus1.lol_count); n_err++;
        end
        bus1.pll_locked = 1'b1;
        tick(264);
        n_cmp++;
        if (rst1() !== 3'b010) begin
            $display("FAIL rel_state: got %b want 010", rst1()); n_err++;
        end
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if ({rst1(), bus1.lol_sticky, bus1.lol_count} !== {3'b110, 1'b0, 8'd0}) begin
            $display("FAIL rel_rst: got %b/%b/%0d want 110/0/0", rst1(), bus1.lol_sticky, bus1.lol_count);
            n_err++;
        end
        rst = 1'b0;
        expect_release("post_rst", 259);
    endtask

    task automatic test_qual_abort();
        bus1.pll_locked = 1'b0;
        tick(5);
        bus1.lol_clear = 1'b1;
        tick(1);
        bus1.lol_clear = 1'b0;
        n_cmp++;
        if ({bus1.lol_sticky, bus1.lol_count} !== {1'b0, 8'd0}) begin
            $display("FAIL clear: got %b/%0d want 0/0", bus1.lol_sticky, bus1.lol_count); n_err++;
        end
        bus1.pll_locked = 1'b1;
        tick(100);
        bus1.pll_locked = 1'b0;
        tick(3);
        bus1.pll_locked = 1'b1;
        // Edge 258 of the original rise is tick 259; the abort must have pushed release past it
        tick(156);
        n_cmp++;
        if (rst1() !== 3'b110) begin
            $display("FAIL abort_no_release: got %b want 110", rst1()); n_err++;
        end
        tick(102);
        n_cmp++;
        if (rst1() !== 3'b110) begin
            $display("FAIL abort_early: got %b want 110", rst1()); n_err++;
        end
        tick(1);
        n_cmp++;
        if ({rst1(), bus1.lol_sticky} !== {3'b010, 1'b0}) begin
            $display("FAIL abort_release: got %b/%b want 010/0", rst1(), bus1.lol_sticky); n_err++;
        end
    endtask

    task automatic test_saturation();
        bus2.pll_locked = 1'b1;
        tick(6);
        n_cmp++;
        if (rst2() !== 3'b110) begin
            $display("FAIL short_early: got %b want 110", rst2()); n_err++;
        end
        tick(1);
        n_cmp++;
        if (rst2() !== 3'b010) begin
            $display("FAIL short_sdram: got %b want 010", rst2()); n_err++;
        end
        tick(1);
        n_cmp++;
        if (rst2() !== 3'b010) begin
            $display("FAIL short_stagger: got %b want 010", rst2()); n_err++;
        end
        tick(1);
        n_cmp++;
        if (rst2() !== 3'b001) begin
            $display("FAIL short_run: got %b want 001", rst2()); n_err++;
        end
        bus2.pll_locked = 1'b0;
        tick(3);
        for (int i = 1; i < 260; i++) begin
            bus2.pll_locked = 1'b1;
            tick(9);
            bus2.pll_locked = 1'b0;
            tick(3);
            if (i == 254) begin
                n_cmp++;
                if (bus2.lol_count !== 8'd255) begin
                    $display("FAIL sat_255: got %0d want 255", bus2.lol_count); n_err++;
                end
            end
        end
        n_cmp++;
        if ({bus2.lol_sticky, bus2.lol_count} !== {1'b1, 8'd255}) begin
            $display("FAIL sat_hold: got %b/%0d want 1/255", bus2.lol_sticky, bus2.lol_count); n_err++;
        end
        bus2.pll_locked = 1'b1;
        tick(9);
        bus2.pll_locked = 1'b0;
        tick(2);
        bus2.lol_clear = 1'b1;
        tick(1);
        bus2.lol_clear = 1'b0;
        n_cmp++;
        if ({rst2(), bus2.lol_sticky, bus2.lol_count} !== {3'b110, 1'b1, 8'd1}) begin
            $display("FAIL clear_vs_loss: got %b/%b/%0d want 110/1/1", rst2(), bus2.lol_sticky, bus2.lol_count);
            n_err++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_powerup();
        test_loss_in_run();
        test_soft_reset();
        test_rst_in_rel();
        test_qual_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
